// File: rtl/pwm_det_pkg.sv
// pwm_det_pkg: shared FSM state type, counter sizing helper and default thresholds for pwm_det.
package pwm_det_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int DEF_THR_HI = 2048;
  localparam int DEF_THR_LO = -2048;
  function automatic int cnt_width_min(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction
endpackage

// File: rtl/pwm_det_hyst_cmp.sv
// hyst_cmp: registered hysteresis comparator producing level plus same-cycle rise/fall strobes.
module hyst_cmp #(
  parameter int IN_WIDTH = 18,
  parameter int THR_HI = 2048,
  parameter int THR_LO = -2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] v_in,
  output logic                       level,
  output logic                       rise,
  output logic                       fall
);
  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'(THR_HI);
  localparam logic signed [IN_WIDTH-1:0] LO = IN_WIDTH'(THR_LO);
  always_comb begin
    rise = !level && (v_in > HI);
    fall = level && (v_in < LO);
  end
  always_ff @(posedge clk)
    if (rst) level <= 1'b0;
    else if (rise || fall) level <= rise;
endmodule

// File: rtl/pwm_det.sv
// pwm_det: recovers a PWM level from an analog sample and measures period/high time; PWM_DET_PEAK_EN adds v_max/v_min.
module pwm_det
  import pwm_det_pkg::*;
#(
  parameter int IN_WIDTH = 18,
  parameter int IN_EXPONENT = -12,
  parameter int THR_HI = DEF_THR_HI,
  parameter int THR_LO = DEF_THR_LO,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] v_in,
  output logic                       level,
  output logic [CNT_WIDTH-1:0]       period,
  output logic [CNT_WIDTH-1:0]       high_time,
  output logic                       meas_valid,
  output logic                       stuck
`ifdef PWM_DET_PEAK_EN
  ,
  output logic signed [IN_WIDTH-1:0] v_max,
  output logic signed [IN_WIDTH-1:0] v_min
`endif
);
  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYC);
  if (THR_LO >= THR_HI) begin : g_bad_thr
    $error("pwm_det: THR_LO must be below THR_HI");
  end
  if (CNT_WIDTH < cnt_width_min(TIMEOUT_CYC)) begin : g_bad_tmo
    $error("pwm_det: TIMEOUT_CYC does not fit in CNT_WIDTH");
  end
  if (IN_EXPONENT >= IN_WIDTH) begin : g_bad_exp
    $error("pwm_det: IN_EXPONENT leaves no fractional range");
  end
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt, hi_cnt, sat_inc;
  logic                 rise, fall, tmo_evt;
  hyst_cmp #(.IN_WIDTH(IN_WIDTH), .THR_HI(THR_HI), .THR_LO(THR_LO)) u_cmp (
    .clk(clk), .rst(rst), .v_in(v_in), .level(level), .rise(rise), .fall(fall)
  );
  // A fall landing exactly on the timeout count holds cnt so it can never pass TIMEOUT_CYC.
  always_comb begin
    sat_inc = (cnt == TMO) ? cnt : cnt + 1'b1;
    tmo_evt = (cnt == TMO) && ((state == HIGH && !fall) || (state == LOW && !rise));
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi_cnt <= '0;
      period <= '0;
      high_time <= '0;
      meas_valid <= 1'b0;
      stuck <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (tmo_evt) begin
        stuck <= 1'b1;
        state <= IDLE;
        cnt <= '0;
      end else if (rise && state != HIGH) begin
        if (state == LOW) begin
          period <= cnt;
          high_time <= hi_cnt;
          meas_valid <= 1'b1;
        end
        stuck <= 1'b0;
        state <= HIGH;
        cnt <= CNT_WIDTH'(1);
      end else if (fall && state == HIGH) begin
        hi_cnt <= cnt;
        state <= LOW;
        cnt <= sat_inc;
      end else if (state != IDLE) cnt <= sat_inc;
    end
`ifdef PWM_DET_PEAK_EN
  logic signed [IN_WIDTH-1:0] run_max, run_min, nxt_max, nxt_min;
  always_comb begin
    nxt_max = (v_in > run_max) ? v_in : run_max;
    nxt_min = (v_in < run_min) ? v_in : run_min;
  end
  always_ff @(posedge clk)
    if (rst || tmo_evt) begin
      v_max <= '0;
      v_min <= '0;
      run_max <= '0;
      run_min <= '0;
    end else if (rise && state != HIGH) begin
      if (state == LOW) begin
        v_max <= nxt_max;
        v_min <= nxt_min;
      end
      run_max <= v_in;
      run_min <= v_in;
    end else if (state != IDLE) begin
      run_max <= nxt_max;
      run_min <= nxt_min;
    end
`endif
endmodule

// File: doc/pwm_det.md
Name: pwm_det

Overview:
Receive-end counterpart of the testbench PWM source. It samples a msdsl fixed-point real, typically the v_out of an analog filter model, and recovers a digital level with a hysteresis comparator. It then measures the period and high time of that level in emulator clock cycles. Intended use is self-checking emulation benches that close the loop PWM -> analog model -> pwm_det.

Parameters:
IN_WIDTH, 18, bit width of signed fixed-point v_in
IN_EXPONENT, -12, binary exponent of v_in LSB (1.0 = 4096 at default); documentation only, no RTL arithmetic
THR_HI, 2048, rising threshold in v_in LSBs (+0.5 at default)
THR_LO, -2048, falling threshold in v_in LSBs (-0.5 at default); THR_LO < THR_HI enforced by elaboration-time check
CNT_WIDTH, 16, width of period/high_time counters
TIMEOUT_CYC, 65535, cycles without an edge before stuck is declared; must be <= 2**CNT_WIDTH-1 (elaboration check)

Ports:
clk  in  1  emulator clock
rst  in  1  synchronous, active-high reset
v_in  in  IN_WIDTH  signed fixed-point analog sample
level  out  1  hysteresis comparator output
period  out  CNT_WIDTH  cycles between last two rising events
high_time  out  CNT_WIDTH  cycles from rising to falling event within that period
meas_valid  out  1  one-cycle pulse when period/high_time update
stuck  out  1  no edge for TIMEOUT_CYC cycles; sticky until next rising event

Behaviour:
- Reset: level=0, period=0, high_time=0, meas_valid=0, stuck=0, cnt=0, state IDLE. Reset mid-operation discards any partial measurement.
- Comparator, registered, 1-cycle latency:
  - Rise event: level=0 and v_in > THR_HI (signed, strict). level<=1 on that edge.
  - Fall event: level=1 and v_in < THR_LO (strict). level<=0 on that edge.
  - v_in equal to a threshold causes no change. Rise and fall are mutually exclusive.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: cnt held at 0. Rise -> HIGH with cnt<=1. The first partial period is never reported.
  - HIGH: cnt increments each cycle. Fall -> hi_cnt<=cnt, LOW, cnt increments.
  - LOW: cnt increments. Rise -> period<=cnt, high_time<=hi_cnt, meas_valid<=1, stuck<=0, HIGH, cnt<=1.
  - Rise in IDLE also clears stuck.
  - Timeout: in HIGH or LOW, cnt==TIMEOUT_CYC with no event that cycle -> stuck<=1, state IDLE, cnt<=0. No meas_valid; period/high_time hold their last values.
- Counting convention: rise events N cycles apart give period=N; rise-to-fall spacing of M gives high_time=M.
- Outputs are registered. meas_valid is asserted in the cycle after the sample that produced the rise event and is low otherwise.
- cnt never exceeds TIMEOUT_CYC, so there is no wrap.

Optional Feature:
PWM_DET_PEAK_EN
- Defined:
  - Adds outputs v_max and v_min (signed IN_WIDTH).
  - Running max/min of v_in is tracked from the rise event through the next rise event, inclusive of the sample that triggered the closing rise.
  - Results are latched alongside period on meas_valid, then tracking restarts from the current sample.
  - Reset and timeout clear v_max/v_min to 0 and restart tracking.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pwm_det_pkg:
  - state enum typedef (IDLE/HIGH/LOW)
  - function computing CNT_WIDTH minimum from TIMEOUT_CYC
  - default threshold constants
- Sub-module hyst_cmp holds the registered comparator with THR_HI/THR_LO. It outputs level plus rise/fall event strobes.
- The FSM, counters, and peak tracking stay in pwm_det.

Test Plan:
- Reset held 5 cycles with arbitrary v_in -> all outputs 0; first rise after release gives no meas_valid.
- v_in square wave +4096/-4096, period 20, high 10 -> from the second rise, meas_valid every 20 cycles with period=20, high_time=10, stuck=0.
- Hysteresis: after rise, v_in steps to +1000, then -2048 (equal to THR_LO), then -2049 -> level stays 1 until the -2049 sample, then falls.
- TIMEOUT_CYC=100, v_in held +4096 after one rise -> stuck=1 exactly 100 cycles after the rise, no meas_valid. Next low/high square wave: stuck clears on the rise, and the first valid measurement comes one period later.
- rst pulsed mid-HIGH of 20/10 wave -> outputs 0; the next report appears after two post-reset rises, with correct 20/10.
- PWM_DET_PEAK_EN, ringing wave with overshoot 5000 and undershoot -4500 within the period -> v_max=5000, v_min=-4500 with meas_valid.
